// File: rtl/keypad_mov_if.sv
// Keypad pin bundle plus the movement/press outputs of keypad_mov.
// master = the scanner, slave = the board/consumer side.
interface keypad_mov_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] mov;
    logic [3:0] key_code;
    logic       key_valid;

    modport master (
        input  key_row,
        output key_col,
        output mov,
        output key_code,
        output key_valid
    );

    modport slave (
        output key_row,
        input  key_col,
        input  mov,
        input  key_code,
        input  key_valid
    );
endinterface

// File: rtl/keypad_mov.sv
// keypad_mov: 4x4 active-low keypad scanner with frame debounce, direction map and press events.
// Optional KEYPAD_DIAG_EN: diagonal keys 1/3/7/9 each drive two direction bits.
module keypad_mov #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    keypad_mov_if.master kp
);
    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]       MATCH_MIN = 4'(DEBOUNCE_FRAMES - 1);

    localparam int K_UP    = 1;
    localparam int K_LEFT  = 4;
    localparam int K_RIGHT = 6;
    localparam int K_DOWN  = 9;
`ifdef KEYPAD_DIAG_EN
    localparam int K_UL    = 0;
    localparam int K_UR    = 2;
    localparam int K_DL    = 8;
    localparam int K_DR    = 10;
`endif

    // state | meaning
    // COL0  | column 0 driven low (key_col = 1110)
    // COL1  | column 1 driven low (key_col = 1101)
    // COL2  | column 2 driven low (key_col = 1011)
    // COL3  | column 3 driven low, its sample closes the frame
    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_slot_cnt;
    logic             w_slot_end;
    logic             w_frame_end;
    logic [3:0]       w_key_col;

    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;

    logic [15:0]      r_raw;
    logic [15:0]      w_raw_nxt;
    logic             r_frame_done;
    logic [15:0]      r_prev;
    logic [3:0]       r_match;
    logic [3:0]       w_match_nxt;
    logic             w_load;
    logic [15:0]      r_stable;
    logic [15:0]      r_new_press;
    logic [3:0]       w_press_code;

    logic             w_up;
    logic             w_down;
    logic             w_left;
    logic             w_right;
    logic [3:0]       w_mov;

    logic [3:0]       r_mov;
    logic [3:0]       r_key_code;
    logic             r_key_valid;

    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_state == COL3);

    // Scan FSM: state register and slot timer
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= COL0;
            r_slot_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_slot_end) begin
            case (r_state)
                COL0:    w_state_nxt = COL1;
                COL1:    w_state_nxt = COL2;
                COL2:    w_state_nxt = COL3;
                COL3:    w_state_nxt = COL0;
                default: w_state_nxt = COL0;
            endcase
        end
    end

    always_comb begin
        w_key_col = 4'b1110;
        case (r_state)
            COL0:    w_key_col = 4'b1110;
            COL1:    w_key_col = 4'b1101;
            COL2:    w_key_col = 4'b1011;
            COL3:    w_key_col = 4'b0111;
            default: w_key_col = 4'b1110;
        endcase
    end

    assign kp.key_col = w_key_col;

    // Rows idle high so the synchroniser resets to "nothing pressed"
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= kp.key_row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Frame bit index is {row, col}, i.e. row*4+col
    always_comb begin
        w_raw_nxt = r_raw;
        for (int r = 0; r < 4; r++) begin
            w_raw_nxt[{2'(r), r_state}] = ~r_row_s2[r];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_raw        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_slot_end) begin
                r_raw <= w_raw_nxt;
            end
        end
    end

    always_comb begin
        w_match_nxt = r_match;
        if (r_raw == r_prev) begin
            if (r_match != 4'd15) begin
                w_match_nxt = r_match + 4'd1;
            end
        end else begin
            w_match_nxt = '0;
        end
    end

    assign w_load = r_frame_done && (w_match_nxt >= MATCH_MIN);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_prev      <= '0;
            r_match     <= '0;
            r_stable    <= '0;
            r_new_press <= '0;
        end else begin
            if (r_frame_done) begin
                r_prev  <= r_raw;
                r_match <= w_match_nxt;
            end
            if (w_load) begin
                r_stable <= r_raw;
            end
            r_new_press <= w_load ? (r_raw & ~r_stable) : '0;
        end
    end

    // Lowest set index wins when several keys land in the same frame
    always_comb begin
        w_press_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_new_press[i]) begin
                w_press_code = 4'(i);
            end
        end
    end

    always_comb begin
        w_up    = r_stable[K_UP];
        w_down  = r_stable[K_DOWN];
        w_left  = r_stable[K_LEFT];
        w_right = r_stable[K_RIGHT];
`ifdef KEYPAD_DIAG_EN
        w_up    = w_up    | r_stable[K_UL] | r_stable[K_UR];
        w_down  = w_down  | r_stable[K_DL] | r_stable[K_DR];
        w_left  = w_left  | r_stable[K_UL] | r_stable[K_DL];
        w_right = w_right | r_stable[K_UR] | r_stable[K_DR];
`endif
        w_mov = {w_up & ~w_down, w_down & ~w_up, w_left & ~w_right, w_right & ~w_left};
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_mov       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_mov       <= w_mov;
            r_key_valid <= |r_new_press;
            if (|r_new_press) begin
                r_key_code <= w_press_code;
            end
        end
    end

    assign kp.mov       = r_mov;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
endmodule

// File: tb/tb_keypad_mov.sv
// Self-checking bench for keypad_mov: table vectors, hand sequences and random key traffic
// against a frame-level keypad model (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
module tb_keypad_mov;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int HIST_N   = 16384;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] keys = '0;

    keypad_mov_if kp ();

    keypad_mov #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .kp       (kp)
    );

    always #5 sys_clk = ~sys_clk;

    // Passive matrix: a held key shorts its row to the column being driven low
    always_comb begin
        kp.key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4'(4 * r + c)] && !kp.key_col[2'(c)]) begin
                    kp.key_row[2'(r)] = 1'b0;
                end
            end
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          pulses  = 0;
    logic [15:0] hist [HIST_N];

    logic [15:0] m_prev;
    logic [15:0] m_stable;
    int          m_match;
    logic [3:0]  exp_mov;
    logic [3:0]  exp_code;
    logic        exp_valid;
    logic        prev_valid;

    // Direction contributed by a single held key: {up, down, left, right}
    function automatic logic [3:0] key_dir(int code);
        case (code)
            1:  return 4'b1000;
            9:  return 4'b0100;
            4:  return 4'b0010;
            6:  return 4'b0001;
`ifdef KEYPAD_DIAG_EN
            0:  return 4'b1010;
            2:  return 4'b1001;
            8:  return 4'b0110;
            10: return 4'b0101;
`endif
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] ref_mov(logic [15:0] held);
        logic [3:0] d = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            if (held[4'(k)]) d = d | key_dir(k);
        end
        if (d[3] && d[2]) d[3:2] = 2'b00;
        if (d[1] && d[0]) d[1:0] = 2'b00;
        return d;
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Frame f column c is seen on the rows during cycle 16f+4c+1; its update is visible at 16f+18
    task automatic model_step();
        int          f;
        logic [15:0] raw;
        logic [15:0] h;
        logic [15:0] newp;
        exp_valid = 1'b0;
        if (cyc >= FRAME + 2 && ((cyc - FRAME - 2) % FRAME) == 0) begin
            f   = (cyc - FRAME - 2) / FRAME;
            raw = '0;
            for (int c = 0; c < 4; c++) begin
                h = hist[FRAME * f + SCAN_DIV * c + 1];
                for (int r = 0; r < 4; r++) begin
                    raw[4'(4 * r + c)] = h[4'(4 * r + c)];
                end
            end
            if (raw == m_prev) begin
                if (m_match < 15) m_match++;
            end else begin
                m_match = 0;
            end
            m_prev = raw;
            if (m_match >= DEB - 1) begin
                newp = raw & ~m_stable;
                if (newp != 16'h0) begin
                    exp_valid = 1'b1;
                    for (int i = 15; i >= 0; i--) begin
                        if (newp[4'(i)]) exp_code = 4'(i);
                    end
                end
                m_stable = raw;
                exp_mov  = ref_mov(raw);
            end
        end
    endtask

    task automatic tick();
        logic [3:0] col_exp;
        if (cyc >= HIST_N - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HIST_N - 1);
            $fatal(1, "cycle budget exhausted");
        end
        hist[cyc] = keys;
        @(posedge sys_clk);
        #1;
        cyc++;
        model_step();
        col_exp = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
        check("key_col", kp.key_col, col_exp);
        check("mov", kp.mov, exp_mov);
        check("key_code", kp.key_code, exp_code);
        check("key_valid", {3'b000, kp.key_valid}, {3'b000, exp_valid});
        check("valid_twice", {3'b000, kp.key_valid & prev_valid}, 4'b0000);
        prev_valid = kp.key_valid;
        if (kp.key_valid) pulses++;
    endtask

    task automatic do_reset(int ncyc);
        sys_rst_n = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            keys = 16'($urandom);
            @(posedge sys_clk);
            #1;
            check("rst_key_col", kp.key_col, 4'b1110);
            check("rst_mov", kp.mov, 4'b0000);
            check("rst_key_valid", {3'b000, kp.key_valid}, 4'b0000);
            check("rst_key_code", kp.key_code, 4'b0000);
        end
        keys       = '0;
        sys_rst_n  = 1'b1;
        cyc        = 0;
        m_prev     = '0;
        m_stable   = '0;
        m_match    = 0;
        exp_mov    = '0;
        exp_code   = '0;
        exp_valid  = 1'b0;
        prev_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          frames;
        logic [3:0]  mov;
        logic [3:0]  code;
        int          pulses;
    } vec_t;

`ifdef KEYPAD_DIAG_EN
    localparam logic [3:0] MOV_KEY9 = 4'b0101;
`else
    localparam logic [3:0] MOV_KEY9 = 4'b0000;
`endif

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"right_6",      16'h0040, 6, 4'b0001, 4'd6,  1};
        vecs[1] = '{"release_6",    16'h0000, 6, 4'b0000, 4'd6,  0};
        vecs[2] = '{"up_down",      16'h0202, 6, 4'b0000, 4'd1,  1};
        vecs[3] = '{"drop_down",    16'h0002, 6, 4'b1000, 4'd1,  0};
        vecs[4] = '{"release_up",   16'h0000, 6, 4'b0000, 4'd1,  0};
        vecs[5] = '{"diag_9",       16'h0400, 6, MOV_KEY9, 4'd10, 1};
        vecs[6] = '{"left_right",   16'h0050, 6, 4'b0000, 4'd4,  1};
        vecs[7] = '{"lr_plus_down", 16'h0250, 6, 4'b0100, 4'd9,  1};
        vecs[8] = '{"release_all",  16'h0000, 6, 4'b0000, 4'd9,  0};

        do_reset(5);

        for (int v = 0; v < 9; v++) begin
            pulses = 0;
            keys   = vecs[v].keys;
            repeat (vecs[v].frames * FRAME) tick();
            check({vecs[v].name, "_mov"}, kp.mov, vecs[v].mov);
            check({vecs[v].name, "_code"}, kp.key_code, vecs[v].code);
            check_int({vecs[v].name, "_pulses"}, pulses, vecs[v].pulses);
        end

        // Left key toggling every 10 cycles never gives a pressed frame pair
        pulses = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            keys = ((i / 10) % 2 == 0) ? 16'h0010 : 16'h0000;
            tick();
        end
        check("bounce_mov", kp.mov, 4'b0000);
        check_int("bounce_pulses", pulses, 0);
        keys = 16'h0010;
        repeat (6 * FRAME) tick();
        check("bounce_clean_mov", kp.mov, 4'b0010);
        check("bounce_clean_code", kp.key_code, 4'd4);

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       keys = 16'($urandom) & 16'($urandom) & 16'($urandom);
                1:       keys = 16'($urandom) & 16'h0656;
                2:       keys = 16'h0000;
                default: keys = 16'h0001 << $urandom_range(0, 15);
            endcase
            repeat ($urandom_range(3, 70)) tick();
        end

        keys = 16'h0202;
        repeat (7) tick();
        do_reset(3);
        keys   = 16'h0040;
        pulses = 0;
        repeat (4 * FRAME) tick();
        check("after_reset_mov", kp.mov, 4'b0001);
        check("after_reset_code", kp.key_code, 4'd6);
        check_int("after_reset_pulses", pulses, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
